// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared definitions for the CIC decimator controller: the sequencer state
// encoding, the minimum legal decimation ratio, the length of the datapath
// clear phase and the default parameter values used by the controller.
// -----------------------------------------------------------------------------
package cic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_WARM  = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int R_MIN         = 2;   // smallest decimation ratio accepted
    localparam int CLEAR_CYCLES  = 2;   // cycles dp_clr is held on a restart

    localparam int DEF_D         = 3;   // comb differential order
    localparam int DEF_R_WIDTH   = 8;   // width of the decimation ratio
    localparam int DEF_CNT_WIDTH = 16;  // width of the output-sample counter

endpackage

// File: rtl/cic_phase_cnt.sv
// -----------------------------------------------------------------------------
// cic_phase_cnt
// Modulo-R phase counter. Counts enabled input strobes 0..r-1 and raises
// 'term' combinationally on the strobe that finds the phase at r-1; that
// strobe wraps the phase back to 0.
//
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   clr   in   synchronous clear of the phase (dominates en)
//   en    in   accepted input strobe
//   r     in   [R_WIDTH] modulus (expected >= 2)
//   term  out  terminal strobe, same cycle as the wrapping en
// -----------------------------------------------------------------------------
module cic_phase_cnt
    import cic_pkg::*;
#(
    parameter int R_WIDTH = DEF_R_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [R_WIDTH-1:0] r,
    output logic               term
);

    logic [R_WIDTH-1:0] phase_q;
    logic [R_WIDTH-1:0] phase_d;

    // NOTE: every signal written here is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        phase_d = phase_q;
        term    = en && !clr && (phase_q == r - R_WIDTH'(1));
        if (clr || term) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + R_WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its _d input regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// cic_decim_ctrl
// Sequencer for a CIC decimator. After a configuration load it clears the
// datapath, lets the integrators run on every input strobe, issues one comb
// strobe per R inputs and marks comb outputs valid once the D-deep comb
// delay line has been filled with fresh samples.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   ND        in   input-sample strobe
//   cfg_r     in   [R_WIDTH] requested decimation ratio
//   cfg_load  in   apply cfg_r and restart (rejected when cfg_r < 2)
//   stop      in   return to idle; wins over cfg_load
//   int_en    out  integrator enable (ND gated by state, combinational)
//   dp_clr    out  synchronous datapath clear, high throughout CLEAR
//   comb_nd   out  comb-stage strobe, one cycle after each terminal ND
//   out_vld   out  comb output valid
//   busy      out  high whenever not IDLE
//   cfg_err   out  one-cycle pulse after a rejected cfg_load
//   out_cnt   out  [CNT_WIDTH] valid outputs since the last restart
// -----------------------------------------------------------------------------
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int D         = DEF_D,
    parameter int R_WIDTH   = DEF_R_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ND,
    input  logic [R_WIDTH-1:0]   cfg_r,
    input  logic                 cfg_load,
    input  logic                 stop,
    output logic                 int_en,
    output logic                 dp_clr,
    output logic                 comb_nd,
    output logic                 out_vld,
    output logic                 busy,
    output logic                 cfg_err,
    output logic [CNT_WIDTH-1:0] out_cnt
);

    localparam int                WARM_W   = $clog2(D + 1);
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(D);
    localparam int                CLR_W    = $clog2(CLEAR_CYCLES + 1);

    state_t               state_q,     state_d;
    logic [R_WIDTH-1:0]   r_q,         r_d;
    logic [CLR_W-1:0]     clr_cnt_q,   clr_cnt_d;
    logic [WARM_W-1:0]    warm_cnt_q,  warm_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q,   out_cnt_d;
    logic                 comb_nd_q,   comb_nd_d;
    logic                 out_vld_q,   out_vld_d;
    logic                 cfg_err_q,   cfg_err_d;

    logic active;
    logic cfg_ok;
    logic load_acc;
    logic load_rej;
    logic term;

    assign active   = (state_q == ST_WARM) || (state_q == ST_RUN);
    assign cfg_ok   = (cfg_r >= R_WIDTH'(R_MIN));
    // stop takes priority: a cfg_load in the same cycle is neither applied
    // nor reported as an error.
    assign load_acc = cfg_load && !stop && cfg_ok;
    assign load_rej = cfg_load && !stop && !cfg_ok;

    assign int_en  = ND && active;
    assign dp_clr  = (state_q == ST_CLEAR);
    assign busy    = (state_q != ST_IDLE);
    assign comb_nd = comb_nd_q;
    assign out_vld = out_vld_q;
    assign cfg_err = cfg_err_q;
    assign out_cnt = out_cnt_q;

    // Phase is held at zero outside WARM/RUN, so every restart begins a
    // fresh decimation period.
    cic_phase_cnt #(
        .R_WIDTH (R_WIDTH)
    ) u_phase (
        .clk  (clk),
        .rst  (rst),
        .clr  (!active),
        .en   (int_en),
        .r    (r_q),
        .term (term)
    );

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        clr_cnt_d  = clr_cnt_q;
        warm_cnt_d = warm_cnt_q;
        out_cnt_d  = out_cnt_q;
        comb_nd_d  = term;
        // Only comb strobes that find the delay line full yield valid data.
        out_vld_d  = comb_nd_q && (warm_cnt_q == WARM_MAX);
        cfg_err_d  = load_rej;

        if (comb_nd_q && (warm_cnt_q != WARM_MAX)) begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
        end
        if (out_vld_q) begin
            out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
            end
            ST_CLEAR: begin
                clr_cnt_d  = clr_cnt_q + CLR_W'(1);
                warm_cnt_d = '0;
                out_cnt_d  = '0;
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d = ST_WARM;
                end
            end
            ST_WARM: begin
                if (warm_cnt_q == WARM_MAX) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Any accepted command drops strobes that would otherwise fire next
        // cycle, so nothing from the old run leaks into the new one.
        if (stop) begin
            state_d   = ST_IDLE;
            comb_nd_d = 1'b0;
            out_vld_d = 1'b0;
        end else if (load_acc) begin
            state_d   = ST_CLEAR;
            r_d       = cfg_r;
            clr_cnt_d = '0;
            comb_nd_d = 1'b0;
            out_vld_d = 1'b0;
        end
    end

    // NOTE: the async reset covers every flop, including r_q, so the block
    // powers up idle with a legal ratio and no stray strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            r_q        <= R_WIDTH'(R_MIN);
            clr_cnt_q  <= '0;
            warm_cnt_q <= '0;
            out_cnt_q  <= '0;
            comb_nd_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            clr_cnt_q  <= clr_cnt_d;
            warm_cnt_q <= warm_cnt_d;
            out_cnt_q  <= out_cnt_d;
            comb_nd_q  <= comb_nd_d;
            out_vld_q  <= out_vld_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_decim_ctrl
// Directed bench for cic_decim_ctrl. Two instances share every input: 'dut'
// uses the default widths, 'dut4' has a 4-bit output counter to exercise the
// wrap. Inputs change 1 time unit after the rising edge; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_cic_decim_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       nd;
    logic [7:0] cfg_r;
    logic       cfg_load;
    logic       stop;

    logic        int_en, dp_clr, comb_nd, out_vld, busy, cfg_err;
    logic [15:0] out_cnt;
    logic        int_en4, dp_clr4, comb_nd4, out_vld4, busy4, cfg_err4;
    logic [3:0]  out_cnt4;

    int checks   = 0;
    int failures = 0;

    cic_decim_ctrl #(.D(3), .R_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ND(nd), .cfg_r(cfg_r), .cfg_load(cfg_load),
        .stop(stop), .int_en(int_en), .dp_clr(dp_clr), .comb_nd(comb_nd),
        .out_vld(out_vld), .busy(busy), .cfg_err(cfg_err), .out_cnt(out_cnt)
    );

    cic_decim_ctrl #(.D(3), .R_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .ND(nd), .cfg_r(cfg_r), .cfg_load(cfg_load),
        .stop(stop), .int_en(int_en4), .dp_clr(dp_clr4), .comb_nd(comb_nd4),
        .out_vld(out_vld4), .busy(busy4), .cfg_err(cfg_err4), .out_cnt(out_cnt4)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observed single-bit outputs: {dp_clr, busy, int_en, comb_nd, out_vld, cfg_err}
    function automatic logic [5:0] obs();
        return {dp_clr, busy, int_en, comb_nd, out_vld, cfg_err};
    endfunction

    function automatic bit on_grid(input int t, input int first, input int period);
        return (t >= first) && (((t - first) % period) == 0);
    endfunction

    task automatic drive(input logic nd_v, input logic load_v,
                         input logic [7:0] r_v, input logic stop_v);
        @(posedge clk);
        #1;
        nd       = nd_v;
        cfg_load = load_v;
        cfg_r    = r_v;
        stop     = stop_v;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        nd       = 1'b0;
        cfg_load = 1'b0;
        stop     = 1'b0;
        cfg_r    = 8'd0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reset state, and release of reset alone must not start anything.
    task automatic test_reset();
        nd       = 1'b1;
        cfg_load = 1'b0;
        stop     = 1'b0;
        cfg_r    = 8'd4;
        rst      = 1'b1;
        #3;
        checks++;
        if (obs() !== 6'b0 || out_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got=%b cnt=%0d exp=000000 cnt=0", obs(), out_cnt);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 1'b0, 8'd4, 1'b0);
            checks++;
            if (obs() !== 6'b0) begin
                failures++;
                $display("FAIL post_reset_idle c=%0d got=%b exp=000000", c, obs());
            end
        end
    endtask

    // D=3, R=4, ND every cycle: clear, warm-up of 3 comb strobes, then outputs.
    task automatic test_warmup();
        logic [5:0] e;
        apply_reset();
        for (int c = 0; c < 32; c++) begin
            drive(1'b1, c == 0, 8'd4, 1'b0);
            e = {c == 1 || c == 2, c >= 1, c >= 3, on_grid(c, 7, 4), on_grid(c, 20, 4), 1'b0};
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL warmup c=%0d got=%b exp=%b", c, obs(), e);
            end
        end
        checks++;
        if (out_cnt !== 16'd3) begin
            failures++;
            $display("FAIL warmup_out_cnt got=%0d exp=3", out_cnt);
        end
    endtask

    // Rejected ratio in IDLE, then again in RUN with R=4 running.
    task automatic test_bad_cfg();
        logic [5:0] e;
        int         t;
        apply_reset();
        for (int c = 0; c < 38; c++) begin
            drive(c >= 2, (c == 0) || (c == 2) || (c == 23), (c == 2) ? 8'd4 : 8'd1, 1'b0);
            t = c - 2;
            e = {t == 1 || t == 2, t >= 1, t >= 3, on_grid(t, 7, 4), on_grid(t, 20, 4),
                 c == 1 || c == 24};
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL bad_cfg c=%0d got=%b exp=%b", c, obs(), e);
            end
        end
    endtask

    // Reload from R=4 to R=8 while RUN, on a cycle with a terminal ND.
    task automatic test_reload();
        logic [5:0] e;
        int         s;
        apply_reset();
        for (int c = 0; c < 68; c++) begin
            drive(1'b1, (c == 0) || (c == 22), (c == 22) ? 8'd8 : 8'd4, 1'b0);
            s = c - 22;
            if (c <= 22) begin
                e = {c == 1 || c == 2, c >= 1, c >= 3, on_grid(c, 7, 4), on_grid(c, 20, 4), 1'b0};
            end else begin
                e = {s == 1 || s == 2, 1'b1, s >= 3, on_grid(s, 11, 8), on_grid(s, 36, 8), 1'b0};
            end
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL reload c=%0d got=%b exp=%b", c, obs(), e);
            end
            if (c == 22 || c == 25 || c == 67) begin
                checks++;
                if (out_cnt !== ((c == 22) ? 16'd1 : (c == 25) ? 16'd0 : 16'd2)) begin
                    failures++;
                    $display("FAIL reload_out_cnt c=%0d got=%0d", c, out_cnt);
                end
            end
        end
    endtask

    // stop with cfg_load together, on the cycle an out_vld is pending.
    task automatic test_stop_and_load();
        logic [5:0] e;
        apply_reset();
        for (int c = 0; c < 27; c++) begin
            drive(1'b1, (c == 0) || (c == 19), (c == 19) ? 8'd5 : 8'd4, c == 19);
            if (c <= 19) begin
                e = {c == 1 || c == 2, c >= 1, c >= 3, on_grid(c, 7, 4), on_grid(c, 20, 4), 1'b0};
            end else begin
                e = 6'b0;
            end
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL stop_load c=%0d got=%b exp=%b", c, obs(), e);
            end
        end
        checks++;
        if (out_cnt !== 16'd0) begin
            failures++;
            $display("FAIL stop_load_out_cnt got=%0d exp=0", out_cnt);
        end
    endtask

    // Asynchronous reset in the middle of RUN, then no activity without a load.
    task automatic test_reset_mid_run();
        apply_reset();
        for (int c = 0; c < 22; c++) begin
            drive(1'b1, c == 0, 8'd4, 1'b0);
        end
        checks++;
        if (out_cnt !== 16'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_setup cnt=%0d busy=%b exp cnt=1 busy=1", out_cnt, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== 6'b0 || out_cnt !== 16'd0) begin
            failures++;
            $display("FAIL mid_run_reset got=%b cnt=%0d exp=000000 cnt=0", obs(), out_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b0, 8'd4, 1'b0);
            checks++;
            if (obs() !== 6'b0) begin
                failures++;
                $display("FAIL mid_run_after c=%0d got=%b exp=000000", c, obs());
            end
        end
    endtask

    // R=2 with random ND gaps until 20 outputs; 4-bit counter must wrap.
    task automatic test_wrap();
        int   gap    = 0;
        int   acc    = 0;
        int   n_comb = 0;
        int   n_vld  = 0;
        bit   term_p = 0;
        bit   vld_p  = 0;
        bit   exp_c, exp_v;
        logic nd_v;
        int   c;
        apply_reset();
        for (c = 0; (n_vld < 20) && (c < 600); c++) begin
            if (gap == 0) begin
                nd_v = 1'b1;
                gap  = $urandom_range(0, 4);
            end else begin
                nd_v = 1'b0;
                gap--;
            end
            drive(nd_v, c == 0, 8'd2, 1'b0);
            exp_c = term_p;
            exp_v = vld_p;
            checks++;
            if ({int_en4, comb_nd4, out_vld4} !== {(c >= 3) && nd_v, exp_c, exp_v}
                || out_cnt4 !== 4'(n_vld) || out_cnt !== 16'(n_vld)) begin
                failures++;
                $display("FAIL wrap c=%0d got ie/cn/ov=%b%b%b cnt4=%0d cnt=%0d exp=%b%b%b cnt=%0d",
                         c, int_en4, comb_nd4, out_vld4, out_cnt4, out_cnt,
                         (c >= 3) && nd_v, exp_c, exp_v, n_vld);
            end
            if (exp_v) n_vld++;
            vld_p = exp_c && (n_comb >= 3);
            if (exp_c) n_comb++;
            term_p = 1'b0;
            if (c >= 3 && nd_v) begin
                acc++;
                term_p = (acc % 2) == 0;
            end
        end
        checks++;
        if (c >= 600) begin
            failures++;
            $display("FAIL wrap_timeout outputs=%0d exp=20", n_vld);
        end
        drive(1'b0, 1'b0, 8'd2, 1'b0);
        checks++;
        if (out_cnt4 !== 4'd4 || out_cnt !== 16'd20) begin
            failures++;
            $display("FAIL wrap_final cnt4=%0d cnt=%0d exp cnt4=4 cnt=20", out_cnt4, out_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_bad_cfg();
        test_reload();
        test_stop_and_load();
        test_reset_mid_run();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
